// File: rtl/gpio_mmio_pkg.sv
// Shared constants and types for the GPIO MMIO controller.
package gpio_mmio_pkg;

  // Word offsets within the 32-byte register window (byte address bits [4:0]).
  localparam logic [4:0] OFF_OUT       = 5'h00;
  localparam logic [4:0] OFF_SET       = 5'h04;
  localparam logic [4:0] OFF_CLR       = 5'h08;
  localparam logic [4:0] OFF_TGL       = 5'h0C;
  localparam logic [4:0] OFF_IN        = 5'h10;
  localparam logic [4:0] OFF_EDGE_EN   = 5'h14;
  localparam logic [4:0] OFF_EDGE_STAT = 5'h18;
  localparam logic [4:0] OFF_IRQ_EN    = 5'h1C;

  // Fall-enable bits live in the upper half of EDGE_EN.
  localparam int FALL_EN_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/gpio_mmio_ctrl_debounce.sv
// Input conditioning: 2-flop synchronizer and per-bit debounce counter.
// A bit of 'stable' only follows the synchronized pin after it has differed
// from 'stable' for DEBOUNCE_CYCLES consecutive cycles. rise/fall pulse in the
// same cycle 'stable' is loaded, so edge status lands on the same edge as IN.
module gpio_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;
  logic [WIDTH-1:0] take;
  logic [CW-1:0]    count [WIDTH];

  // Terminal-count detect: synchronized value has held long enough to accept.
  always_comb begin
    take = '0;
    for (int i = 0; i < WIDTH; i++) begin
      take[i] = (sync_b[i] != stable[i]) && (count[i] == CNT_TC);
    end
  end

  assign rise = take & sync_b;
  assign fall = take & ~sync_b;

  // Synchronizer, per-bit counters and the accepted stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) count[i] <= '0;
    end else begin
      sync_a <= pin;
      sync_b <= sync_a;
      for (int i = 0; i < WIDTH; i++) begin
        if (take[i]) begin
          stable[i] <= sync_b[i];
          count[i]  <= '0;
        end else if (sync_b[i] != stable[i]) begin
          count[i] <= count[i] + 1'b1;
        end else begin
          count[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_mmio_ctrl.sv
// GPIO port on the core bus: output register with set/clear/toggle aliases,
// debounced input with edge status and a level interrupt.
//
// state | meaning
// IDLE  | waiting for bus_req; an access is captured on the edge it is seen
// RESP  | bus_ready high for one cycle, bus_rdata valid
module gpio_mmio_ctrl
  import gpio_mmio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [31:0]      BASE_ADDR       = 32'h1000_0000,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  input  logic [WIDTH-1:0] gpio_port_in,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic             irq
);

  bus_state_t       state;
  bus_state_t       state_next;
  logic             accept;
  logic             hit;
  logic             wr;
  logic [4:0]       off;
  logic [31:0]      rd_val;
  logic [31:0]      rdata_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_stat;
  logic [WIDTH-1:0] w1c;
  logic             irq_en;
  logic [WIDTH-1:0] in_stable;
  logic [WIDTH-1:0] in_rise;
  logic [WIDTH-1:0] in_fall;
  logic             unused_bits;

  // Byte-lane bits and wdata bits above the field widths carry no meaning.
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  gpio_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .pin    (gpio_port_in),
    .stable (in_stable),
    .rise   (in_rise),
    .fall   (in_fall)
  );

  assign accept = (state == IDLE) && bus_req;
  assign hit    = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign off    = {bus_addr[4:2], 2'b00};
  assign wr     = accept && hit && bus_we;

  // State register for the bus handshake.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: every accepted access gets exactly one RESP cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus_req) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read mux; misses, writes and write-only aliases return zero.
  always_comb begin
    rd_val = '0;
    if (hit && !bus_we) begin
      case (off)
        OFF_OUT:       rd_val = 32'(out_q);
        OFF_IN:        rd_val = 32'(in_stable);
        OFF_EDGE_EN:   rd_val = 32'(rise_en) | (32'(fall_en) << FALL_EN_LSB);
        OFF_EDGE_STAT: rd_val = 32'(edge_stat);
        OFF_IRQ_EN:    rd_val = {31'd0, irq_en};
        default:       rd_val = '0;
      endcase
    end
  end

  // Write-one-to-clear mask for EDGE_STAT.
  always_comb begin
    w1c = '0;
    if (wr && (off == OFF_EDGE_STAT)) w1c = bus_wdata[WIDTH-1:0];
  end

  // Register file, edge status (new events beat W1C), interrupt and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= OUT_RESET;
      rise_en   <= '0;
      fall_en   <= '0;
      edge_stat <= '0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (wr) begin
        case (off)
          OFF_OUT:     out_q   <= bus_wdata[WIDTH-1:0];
          OFF_SET:     out_q   <= out_q | bus_wdata[WIDTH-1:0];
          OFF_CLR:     out_q   <= out_q & ~bus_wdata[WIDTH-1:0];
          OFF_TGL:     out_q   <= out_q ^ bus_wdata[WIDTH-1:0];
          OFF_EDGE_EN: begin
            rise_en <= bus_wdata[WIDTH-1:0];
            fall_en <= bus_wdata[FALL_EN_LSB+WIDTH-1:FALL_EN_LSB];
          end
          OFF_IRQ_EN:  irq_en  <= bus_wdata[0];
          default:     ;
        endcase
      end
      edge_stat <= (edge_stat & ~w1c) | (in_rise & rise_en) | (in_fall & fall_en);
      irq       <= irq_en & (|edge_stat);
      rdata_q   <= accept ? rd_val : '0;
    end
  end

  assign bus_ready     = (state == RESP);
  assign bus_rdata     = rdata_q;
  assign gpio_port_out = out_q;

endmodule

// File: tb/tb_gpio_mmio_ctrl.sv
// Self-checking bench for gpio_mmio_ctrl: directed literal checks plus a
// randomized phase compared every cycle against a behavioural model.
module tb_gpio_mmio_ctrl;

  localparam int          DEB     = 4;
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] MISS    = 32'h2000_0000;
  localparam logic [7:0]  OUT_RST = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;
  bit rand_pins = 1'b0;

  gpio_mmio_ctrl #(
    .WIDTH           (8),
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DEB),
    .OUT_RESET       (OUT_RST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ready     (bus_ready),
    .gpio_port_in  (gpio_port_in),
    .gpio_port_out (gpio_port_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pins seen two cycles late, a bit of IN flips once the
  // last DEB seen samples all disagree with it; bus accesses complete one
  // cycle after being seen while not busy.
  logic [7:0]  m_out, m_rise, m_fall, m_stat, m_stable, m_pd1, m_pd2;
  logic [7:0]  m_hist [DEB];
  logic        m_irq_en, m_irq, m_busy;
  logic [31:0] m_rdata;

  always @(posedge clk) begin : model
    logic [7:0]  seen, nstab, ev, w1c;
    logic [31:0] rd;
    logic        allopp, nirq, hit;
    logic [4:0]  off;
    if (rst) begin
      m_out = OUT_RST; m_rise = 0; m_fall = 0; m_stat = 0; m_stable = 0;
      m_irq_en = 0; m_irq = 0; m_busy = 0; m_rdata = 0; m_pd1 = 0; m_pd2 = 0;
      for (int k = 0; k < DEB; k++) m_hist[k] = 8'h00;
    end else begin
      seen  = m_pd2;
      m_pd2 = m_pd1;
      m_pd1 = gpio_port_in;
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = seen;
      nstab = m_stable;
      ev    = 8'h00;
      for (int b = 0; b < 8; b++) begin
        allopp = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_hist[k][b] == m_stable[b]) allopp = 1'b0;
        if (allopp) begin
          nstab[b] = ~m_stable[b];
          ev[b]    = nstab[b] ? m_rise[b] : m_fall[b];
        end
      end
      nirq = m_irq_en && (m_stat != 8'h00);
      rd   = 32'h0;
      w1c  = 8'h00;
      if (!m_busy && bus_req) begin
        hit = (bus_addr[31:5] == BASE[31:5]);
        off = {bus_addr[4:2], 2'b00};
        if (hit && !bus_we) begin
          case (off)
            5'h00:   rd = {24'h0, m_out};
            5'h10:   rd = {24'h0, m_stable};
            5'h14:   rd = {8'h0, m_fall, 8'h0, m_rise};
            5'h18:   rd = {24'h0, m_stat};
            5'h1C:   rd = {31'h0, m_irq_en};
            default: rd = 32'h0;
          endcase
        end
        if (hit && bus_we) begin
          case (off)
            5'h00:   m_out = bus_wdata[7:0];
            5'h04:   m_out = m_out | bus_wdata[7:0];
            5'h08:   m_out = m_out & ~bus_wdata[7:0];
            5'h0C:   m_out = m_out ^ bus_wdata[7:0];
            5'h14:   begin m_rise = bus_wdata[7:0]; m_fall = bus_wdata[23:16]; end
            5'h18:   w1c = bus_wdata[7:0];
            5'h1C:   m_irq_en = bus_wdata[0];
            default: ;
          endcase
        end
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      m_rdata  = rd;
      m_stat   = (m_stat & ~w1c) | ev;
      m_stable = nstab;
      m_irq    = nirq;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_ready", 32'(bus_ready), 32'(m_busy));
      chk("cyc_rdata", bus_rdata, m_rdata);
      chk("cyc_out", 32'(gpio_port_out), 32'(m_out));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_pins && ($urandom_range(0, 3) == 0))
        gpio_port_in = gpio_port_in ^ (8'($urandom) & 8'($urandom));
    end
  endtask

  task automatic set_pins(input logic [7:0] v);
    @(posedge clk);
    #1 gpio_port_in = v;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic [7:0] out_seen, output int lat);
    bit got = 1'b0;
    rdata = 32'h0; out_seen = 8'h00; lat = -1;
    @(posedge clk);
    #1;
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus_ready) begin
        got = 1'b1; lat = k; rdata = bus_rdata; out_seen = gpio_port_out;
        bus_req = 1'b0;
      end
    end
    bus_req = 1'b0;
    chk("bus_timeout", 32'(got), 32'd1);
  endtask

  logic [31:0] rd;
  logic [7:0]  o;
  int          lat;
  int          first, second;

  initial begin
    rst = 1'b1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; gpio_port_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_out", 32'(gpio_port_out), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ready", 32'(bus_ready), 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);

    xfer(1'b0, BASE + 32'h00, 32'h0, rd, o, lat);
    chk("rd_out_after_rst", rd, 32'h0);
    chk("ready_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("ready_one_cycle", 32'(bus_ready), 32'h0);
    xfer(1'b0, BASE + 32'h10, 32'h0, rd, o, lat);
    chk("rd_in_after_rst", rd, 32'h0);

    xfer(1'b1, BASE + 32'h00, 32'hA5, rd, o, lat); chk("wr_out", 32'(o), 32'hA5);
    xfer(1'b1, BASE + 32'h04, 32'h0F, rd, o, lat); chk("wr_set", 32'(o), 32'hAF);
    xfer(1'b1, BASE + 32'h08, 32'h05, rd, o, lat); chk("wr_clr", 32'(o), 32'hAA);
    xfer(1'b1, BASE + 32'h0C, 32'hFF, rd, o, lat); chk("wr_tgl", 32'(o), 32'h55);
    xfer(1'b0, BASE + 32'h04, 32'h0, rd, o, lat);  chk("rd_set_alias", rd, 32'h0);
    xfer(1'b0, BASE + 32'h00, 32'h0, rd, o, lat);  chk("rd_out_back", rd, 32'h55);

    set_pins(8'h03);
    xfer(1'b0, BASE + 32'h10, 32'h0, rd, o, lat); chk("in_early", rd, 32'h00);
    idle(8);
    xfer(1'b0, BASE + 32'h10, 32'h0, rd, o, lat); chk("in_settled", rd, 32'h03);
    set_pins(8'h83);
    idle(2);
    set_pins(8'h03);
    idle(10);
    xfer(1'b0, BASE + 32'h10, 32'h0, rd, o, lat); chk("in_glitch", rd, 32'h03);

    set_pins(8'h00);
    idle(10);
    xfer(1'b1, BASE + 32'h14, 32'h0000_0001, rd, o, lat);
    xfer(1'b1, BASE + 32'h1C, 32'h1, rd, o, lat);
    xfer(1'b0, BASE + 32'h14, 32'h0, rd, o, lat); chk("rd_edge_en", rd, 32'h0000_0001);
    set_pins(8'h01);
    idle(10);
    xfer(1'b0, BASE + 32'h18, 32'h0, rd, o, lat); chk("stat_rise", rd, 32'h01);
    chk("irq_set", 32'(irq), 32'h1);
    xfer(1'b1, BASE + 32'h18, 32'h01, rd, o, lat);
    xfer(1'b0, BASE + 32'h18, 32'h0, rd, o, lat); chk("stat_w1c", rd, 32'h00);
    idle(2);
    chk("irq_clear", 32'(irq), 32'h0);
    set_pins(8'h00);
    idle(10);
    xfer(1'b0, BASE + 32'h18, 32'h0, rd, o, lat); chk("stat_fall_off", rd, 32'h00);
    set_pins(8'h01);
    idle(10);
    chk("irq_rise2", 32'(irq), 32'h1);

    xfer(1'b0, MISS, 32'h0, rd, o, lat); chk("miss_rd", rd, 32'h0);
    xfer(1'b1, MISS, 32'hFF, rd, o, lat); chk("miss_wr_out", 32'(o), 32'h55);

    @(posedge clk);
    #1 bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE;
    first = -1; second = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_ready) begin
        if (first < 0) first = k;
        else if (second < 0) begin second = k; bus_req = 1'b0; end
      end
    end
    bus_req = 1'b0;
    chk("b2b_first", 32'(first), 32'd1);
    chk("b2b_gap", 32'(second - first), 32'd2);

    @(posedge clk);
    #1 bus_req = 1'b1; bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h3C;
    for (int k = 0; k < 8 && !bus_ready; k++) @(negedge clk);
    chk("rst_resp_seen", 32'(bus_ready), 32'h1);
    bus_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_ready", 32'(bus_ready), 32'h0);
    chk("rst_resp_out", 32'(gpio_port_out), 32'(OUT_RST));
    chk("rst_resp_irq", 32'(irq), 32'h0);

    rand_pins = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      idle($urandom_range(0, 3));
      a = 32'($urandom_range(0, 7)) << 2;
      a = (($urandom_range(0, 7) == 0) ? MISS : BASE) | a;
      xfer(1'($urandom_range(0, 1)), a, $urandom, rd, o, lat);
    end
    rand_pins = 1'b0;
    idle(5);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_mmio_ctrl.md
Name: gpio_mmio_ctrl

Overview:
Memory-mapped controller that places the SoC's 8-bit GPIO port on the core's data bus.
- Output side: drives gpio_port_out through a register plus write-only set, clear and toggle aliases.
- Input side: synchronizes and debounces gpio_port_in, detects edges and raises a level interrupt.
- Sits between the core's load/store path and the board pins; uses a single-outstanding req/ready handshake.

Parameters:
WIDTH, 8, GPIO port width (1..16)
BASE_ADDR, 32'h1000_0000, base of a 32-byte register window
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept an input change (>=1)
OUT_RESET, 8'h00, reset value of the OUT register

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bus_req  in  1  access request, held until bus_ready
bus_we  in  1  1=write, 0=read
bus_addr  in  32  byte address; bits [1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid while bus_ready=1
bus_ready  out  1  one-cycle completion pulse
gpio_port_in  in  WIDTH  asynchronous pin inputs
gpio_port_out  out  WIDTH  registered pin outputs (= OUT register)
irq  out  1  registered interrupt, level

Behaviour:
- Reset, synchronous, wins over everything in the same cycle:
  - OUT=OUT_RESET; all other registers, synchronizers, debounce counters and stable value = 0.
  - bus_ready=0, bus_rdata=0, irq=0, FSM=IDLE.
- Register map (offset; reads of unused bits return 0):
  - 0x00 OUT (RW)
  - 0x04 OUT_SET (W): OUT |= wdata
  - 0x08 OUT_CLR (W): OUT &= ~wdata
  - 0x0C OUT_TGL (W): OUT ^= wdata
  - 0x10 IN (RO): debounced value
  - 0x14 EDGE_EN (RW): [WIDTH-1:0] rise enable, [WIDTH+15:16] fall enable
  - 0x18 EDGE_STAT (R/W1C)
  - 0x1C IRQ_EN (RW): bit 0
  - Reads of write-only aliases return 0.
- Bus FSM, states IDLE and RESP:
  - IDLE with bus_req=1: capture the access. A write takes effect at this clock edge; read data is latched at this edge. Go to RESP.
  - RESP: bus_ready=1 for exactly one cycle with bus_rdata valid, then back to IDLE. bus_rdata returns to 0 in IDLE.
  - Latency is 1 cycle from acceptance to ready; maximum throughput is one access per 2 cycles.
  - A bus_req still high in the cycle after RESP is treated as a new access. The requester must drop or change it on ready.
- Address decode: hit when addr[31:5]==BASE_ADDR[31:5].
  - Miss: writes are ignored, reads return 0, bus_ready is still pulsed (no hang).
- gpio_port_out updates on the edge the write is accepted, so it is visible in the RESP cycle.
- Input path:
  - 2-flop synchronizer per bit.
  - Per-bit counter: increments while sync != stable, clears while sync == stable.
  - When count reaches DEBOUNCE_CYCLES-1 with sync still != stable, stable <= sync and count clears.
  - Pin-to-IN latency = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles after synchronization never reaches IN.
- Edge detect on stable value:
  - Rise with rise enable, or fall with fall enable, sets EDGE_STAT bit.
  - W1C in the same cycle as a new set: the set wins.
  - Events while the enable is 0 are lost, including the post-reset settling of tied-high pins.
- irq: registered, irq <= IRQ_EN[0] & |EDGE_STAT. It lags the status change by 1 cycle.
- Reset during RESP: bus_ready drops that cycle and the access is discarded. A write already accepted stays applied unless reset was asserted on the acceptance edge.

Decomposition:
- Package gpio_mmio_pkg:
  - Register offset constants (OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL, OFF_IN, OFF_EDGE_EN, OFF_EDGE_STAT, OFF_IRQ_EN).
  - Bus FSM state enum {IDLE, RESP}.
- One sub-module, gpio_debounce: synchronizer plus per-bit counters, WIDTH-wide vector.
  - Outputs the stable vector and a one-cycle rise/fall pulse vector.

Test Plan:
- Reset then read OUT (0x00) and IN (0x10) -> both 0; bus_ready pulses exactly 1 cycle after req; gpio_port_out=0x00.
- Write OUT=0xA5; SET 0x0F; CLR 0x05; TGL 0xFF -> gpio_port_out 0xA5, 0xAF, 0xAA, 0x55, each visible in its RESP cycle.
- gpio_port_in=0x03 held -> IN reads 0x00 before cycle 6 and 0x03 from cycle 2+4=6 after the change. A 3-cycle 0x80 pulse -> IN bit7 never set.
- EDGE_EN=0x0001, IRQ_EN=1, pin0 0->1:
  - EDGE_STAT=0x01, then irq=1 one cycle later.
  - W1C 0x01 -> EDGE_STAT=0, then irq=0.
  - Fall on pin0 -> no status.
- Read 0x2000_0000 and write 0x2000_0000=0xFF -> rdata=0, ready pulses, OUT unchanged. Back-to-back req held high -> second access completes 2 cycles after the first.
- Assert rst during RESP -> bus_ready=0 next cycle, FSM IDLE, OUT=OUT_RESET, irq=0.
